alu_issue_unit: RTL and testbench

- Sits directly upstream of the ALU and owns its operand/opcode inputs.
- Decodes RISC-V RV32IM arithmetic fields into the 5-bit ALU opcode and drives stable operands for the op's full latency.
- Counts per-class latency and applies RISC-V divide corner-case overrides.
- Returns the result to writeback over a valid/ready handshake.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_op_decoder.sv | 81 ++++++++
 rtl/alu_issue_unit.sv | 137 +++++++++++++
 tb/tb_alu_issue_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, funct7 constants and state/latency-class encodings
// for the ALU issue unit.
package alu_pkg;

  localparam logic [4:0] OP_ADD    = 5'b00000;
  localparam logic [4:0] OP_SUB    = 5'b00001;
  localparam logic [4:0] OP_MUL    = 5'b00010;
  localparam logic [4:0] OP_MULH   = 5'b00011;
  localparam logic [4:0] OP_MULHSU = 5'b00100;
  localparam logic [4:0] OP_MULHU  = 5'b00101;
  localparam logic [4:0] OP_DIV    = 5'b00110;
  localparam logic [4:0] OP_DIVU   = 5'b00111;
  localparam logic [4:0] OP_REM    = 5'b01000;
  localparam logic [4:0] OP_REMU   = 5'b01001;
  localparam logic [4:0] OP_AND    = 5'b01010;
  localparam logic [4:0] OP_OR     = 5'b01011;
  localparam logic [4:0] OP_XOR    = 5'b01100;
  localparam logic [4:0] OP_SLL    = 5'b01110;
  localparam logic [4:0] OP_SRL    = 5'b01111;
  localparam logic [4:0] OP_SRA    = 5'b10000;
  localparam logic [4:0] OP_SLT    = 5'b10001;
  localparam logic [4:0] OP_SLTU   = 5'b10010;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
  typedef enum logic [1:0] {LC_BASIC, LC_MUL, LC_DIV} lat_class_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32IM OP/OP-IMM decode into the 5-bit ALU opcode, plus
// latency class and the divide corner-case flags.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        is_imm,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [4:0]  opcode,
  output lat_class_t  lat_class,
  output logic        illegal,
  output logic        div_zero,
  output logic        overflow
);

  // Field decode; illegal encodings collapse to ADD/basic so nothing odd reaches the ALU
  always_comb begin
    opcode    = OP_ADD;
    lat_class = LC_BASIC;
    illegal   = 1'b0;
    if (is_imm) begin
      case (funct3)
        3'b000: opcode = OP_ADD;
        3'b010: opcode = OP_SLT;
        3'b011: opcode = OP_SLTU;
        3'b100: opcode = OP_XOR;
        3'b110: opcode = OP_OR;
        3'b111: opcode = OP_AND;
        3'b001: begin
          if (funct7 == F7_BASE) opcode = OP_SLL;
          else                   illegal = 1'b1;
        end
        default: begin // 3'b101
          if      (funct7 == F7_BASE) opcode = OP_SRL;
          else if (funct7 == F7_ALT)  opcode = OP_SRA;
          else                        illegal = 1'b1;
        end
      endcase
    end else begin
      case (funct7)
        F7_BASE: begin
          case (funct3)
            3'b000:  opcode = OP_ADD;
            3'b001:  opcode = OP_SLL;
            3'b010:  opcode = OP_SLT;
            3'b011:  opcode = OP_SLTU;
            3'b100:  opcode = OP_XOR;
            3'b101:  opcode = OP_SRL;
            3'b110:  opcode = OP_OR;
            default: opcode = OP_AND;
          endcase
        end
        F7_ALT: begin
          if      (funct3 == 3'b000) opcode = OP_SUB;
          else if (funct3 == 3'b101) opcode = OP_SRA;
          else                       illegal = 1'b1;
        end
        F7_MULDIV: begin
          // MUL..REMU are contiguous in funct3 order starting at OP_MUL
          opcode    = OP_MUL + {2'b00, funct3};
          lat_class = funct3[2] ? LC_DIV : LC_MUL;
        end
        default: illegal = 1'b1;
      endcase
    end
    if (illegal) begin
      opcode    = OP_ADD;
      lat_class = LC_BASIC;
    end
  end

  // Divide corner cases that bypass the ALU entirely
  always_comb begin
    div_zero = (lat_class == LC_DIV) && (rs2 == 32'h0);
    overflow = ((opcode == OP_DIV) || (opcode == OP_REM)) &&
               (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue unit in front of a multi-cycle ALU: decodes, holds operands for the
// op's latency, overrides divide corner cases and hands the result to
// writeback over valid/ready.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int BASIC_LAT = 2,
  parameter int MUL_LAT   = 4,
  parameter int DIV_LAT   = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic        in_is_imm,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2_imm,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [4:0]  alu_opcode,
  input  logic [31:0] alu_answer,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_illegal
);

  localparam int MAX_LAT = (BASIC_LAT > MUL_LAT) ?
                           ((BASIC_LAT > DIV_LAT) ? BASIC_LAT : DIV_LAT) :
                           ((MUL_LAT   > DIV_LAT) ? MUL_LAT   : DIV_LAT);
  localparam int CW = $clog2(MAX_LAT) + 1;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  lat;
  logic [4:0]     dec_opcode;
  lat_class_t     dec_class;
  logic           dec_illegal;
  logic           dec_div_zero;
  logic           dec_overflow;
  logic           fast;
  logic [31:0]    fast_result;

  alu_op_decoder u_dec (
    .funct3    (in_funct3),
    .funct7    (in_funct7),
    .is_imm    (in_is_imm),
    .rs1       (in_rs1),
    .rs2       (in_rs2_imm),
    .opcode    (dec_opcode),
    .lat_class (dec_class),
    .illegal   (dec_illegal),
    .div_zero  (dec_div_zero),
    .overflow  (dec_overflow)
  );

  // Accept only in IDLE and never while reset is held
  assign in_ready = (state == ST_IDLE) && !rst;

  // Class latency and the result forced for ops that skip the ALU
  always_comb begin
    case (dec_class)
      LC_MUL:  lat = CW'(MUL_LAT);
      LC_DIV:  lat = CW'(DIV_LAT);
      default: lat = CW'(BASIC_LAT);
    endcase
    fast        = dec_illegal || dec_div_zero || dec_overflow;
    fast_result = 32'h0;
    if (dec_div_zero)
      fast_result = ((dec_opcode == OP_DIV) || (dec_opcode == OP_DIVU)) ?
                    32'hFFFF_FFFF : in_rs1;
    else if (dec_overflow)
      fast_result = (dec_opcode == OP_DIV) ? 32'h8000_0000 : 32'h0;
  end

  // Issue FSM: accept, count down the ALU latency, then hold until handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      alu_op1     <= '0;
      alu_op2     <= '0;
      alu_opcode  <= OP_ADD;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            alu_op1     <= in_rs1;
            alu_op2     <= in_rs2_imm;
            alu_opcode  <= dec_opcode;
            out_rd      <= in_rd;
            out_illegal <= dec_illegal;
            if (fast) begin
              // Result is known now; out_valid follows one edge later in DONE
              state      <= ST_DONE;
              out_result <= fast_result;
              cnt        <= '0;
            end else begin
              state <= ST_BUSY;
              cnt   <= lat;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            out_result <= alu_answer;
            out_valid  <= 1'b1;
            state      <= ST_DONE;
          end
        end
        default: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Randomized + directed bench for alu_issue_unit with a behavioural ALU and
// an RV32IM reference model.
module tb_alu_issue_unit;

  localparam int BL = 2;
  localparam int ML = 4;
  localparam int DL = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic        in_is_imm;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2_imm;
  logic [4:0]  in_rd;
  logic        flush;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_answer;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.BASIC_LAT(BL), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_is_imm(in_is_imm),
    .in_rs1(in_rs1), .in_rs2_imm(in_rs2_imm), .in_rd(in_rd), .flush(flush),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opcode(alu_opcode),
    .alu_answer(alu_answer), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_illegal(out_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Arithmetic by opcode. rv=1 applies RISC-V divide corner rules; rv=0 is the
  // raw ALU, which returns junk on those corners so a missing override shows.
  function automatic logic [31:0] sem(input logic [4:0] op, input logic [31:0] a,
                                      input logic [31:0] b, input logic rv);
    logic signed [31:0] sa, sb;
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic               z, ov;
    sa = a; sb = b;
    z  = (b == 32'h0);
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a * b;
      5'd3:  begin sp = 64'(sa) * 64'(sb); return sp[63:32]; end
      5'd4:  begin sp = 64'(sa) * $signed({32'h0, b}); return sp[63:32]; end
      5'd5:  begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      5'd6:  if (z) return rv ? 32'hFFFF_FFFF : 32'hDEAD_BEEF;
             else if (ov) return rv ? 32'h8000_0000 : 32'hDEAD_BEEF;
             else return sa / sb;
      5'd7:  if (z) return rv ? 32'hFFFF_FFFF : 32'hDEAD_BEEF; else return a / b;
      5'd8:  if (z) return rv ? a : 32'hDEAD_BEEF;
             else if (ov) return rv ? 32'h0 : 32'hDEAD_BEEF;
             else return sa % sb;
      5'd9:  if (z) return rv ? a : 32'hDEAD_BEEF; else return a % b;
      5'd10: return a & b;
      5'd11: return a | b;
      5'd12: return a ^ b;
      5'd14: return a << b[4:0];
      5'd15: return a >> b[4:0];
      5'd16: return sa >>> b[4:0];
      5'd17: return {31'h0, sa < sb};
      5'd18: return {31'h0, a < b};
      default: return 32'hBAD0_BAD0;
    endcase
  endfunction

  assign alu_answer = sem(alu_opcode, alu_op1, alu_op2, 1'b0);

  // Reference: instruction fields -> expected opcode, legality, result, latency
  task automatic ref_model(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [4:0] op, output logic ill,
                           output logic [31:0] res, output int lat);
    logic [4:0] base_tbl [8];
    base_tbl = '{5'd0, 5'd14, 5'd17, 5'd18, 5'd12, 5'd15, 5'd11, 5'd10};
    ill = 1'b0; op = 5'd0;
    if (imm) begin
      if (f3 == 3'b001)      begin if (f7 == 7'h00) op = 5'd14; else ill = 1'b1; end
      else if (f3 == 3'b101) begin
        if (f7 == 7'h00) op = 5'd15; else if (f7 == 7'h20) op = 5'd16; else ill = 1'b1;
      end else op = base_tbl[f3];
    end else if (f7 == 7'h00) op = base_tbl[f3];
    else if (f7 == 7'h20) begin
      if (f3 == 3'b000) op = 5'd1; else if (f3 == 3'b101) op = 5'd16; else ill = 1'b1;
    end else if (f7 == 7'h01) op = 5'd2 + 5'(f3);
    else ill = 1'b1;
    if (ill) begin op = 5'd0; res = 32'h0; lat = 1; end
    else begin
      res = sem(op, a, b, 1'b1);
      if (op >= 5'd6 && op <= 5'd9)
        lat = (b == 0 || ((op == 5'd6 || op == 5'd8) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : DL;
      else if (op >= 5'd2 && op <= 5'd5) lat = ML;
      else lat = BL;
    end
  endtask

  // Wait for in_ready and present one instruction; returns just after the accept edge
  task automatic issue(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'h1);
    in_funct3 = f3; in_funct7 = f7; in_is_imm = imm;
    in_rs1 = a; in_rs2_imm = b; in_rd = rd; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Full transaction with latency, hold, result and backpressure checks
  task automatic run_op(input logic [2:0] f3, input logic [6:0] f7, input logic imm,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold);
    logic [4:0]  eop;
    logic        eill;
    logic [31:0] eres;
    int          elat, k;
    bit          got;
    ref_model(f3, f7, imm, a, b, eop, eill, eres, elat);
    issue(f3, f7, imm, a, b, rd);
    k = 0; got = 0;
    while (k < DL + 10 && !got) begin
      if (!eill) begin
        chk("hold_opcode", 32'(alu_opcode), 32'(eop));
        chk("hold_op1", alu_op1, a);
      end
      @(posedge clk); #1; k++;
      if (out_valid) got = 1;
    end
    if (!got) begin chk("valid_timeout", 32'(out_valid), 32'h1); return; end
    chk("latency", 32'(k), 32'(elat));
    chk("result", out_result, eres);
    chk("rd", 32'(out_rd), 32'(rd));
    chk("illegal", 32'(out_illegal), 32'(eill));
    chk("no_overlap", 32'(in_ready), 32'h0);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(out_valid), 32'h1);
      chk("stall_result", out_result, eres);
      chk("stall_rd", 32'(out_rd), 32'(rd));
      chk("stall_ready", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'h0);
    chk("back_idle", 32'(in_ready), 32'h1);
  endtask

  initial begin
    logic [6:0]  f7;
    logic [31:0] a, b;
    int          risen;
    rst = 1'b1; in_valid = 0; in_funct3 = 0; in_funct7 = 0; in_is_imm = 0;
    in_rs1 = 0; in_rs2_imm = 0; in_rd = 0; flush = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_opcode", 32'(alu_opcode), 32'h0);
    chk("rst_op1", alu_op1, 32'h0);
    rst = 1'b0;

    // Directed cases
    run_op(3'b000, 7'h00, 1'b0, 32'd5, 32'd7, 5'd3, 0);              // ADD
    run_op(3'b011, 7'h01, 1'b0, 32'hFFFF_FFFF, 32'd2, 5'd9, 1);      // MULHU
    run_op(3'b101, 7'h01, 1'b0, 32'h1234, 32'h0, 5'd4, 0);           // DIVU /0
    run_op(3'b111, 7'h01, 1'b0, 32'h1234, 32'h0, 5'd5, 0);           // REMU /0
    run_op(3'b100, 7'h01, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0); // DIV ovf
    run_op(3'b110, 7'h01, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0); // REM ovf
    run_op(3'b100, 7'h20, 1'b0, 32'd1, 32'd2, 5'd8, 0);              // illegal OP
    run_op(3'b001, 7'h01, 1'b1, 32'd1, 32'd2, 5'd10, 0);             // illegal SLLI
    run_op(3'b101, 7'h20, 1'b1, 32'h8000_00F0, 32'h404, 5'd11, 5);   // SRAI, stall 5
    run_op(3'b100, 7'h01, 1'b0, 32'hFFFF_FF9C, 32'd7, 5'd12, 0);     // DIV -100/7

    // Randomized
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: f7 = 7'h00;
        3:       f7 = 7'h20;
        4, 5:    f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(0, 31);
        default: ;
      endcase
      run_op(3'($urandom), f7, 1'($urandom), a, b, 5'($urandom), $urandom_range(0, 3));
    end

    // Flush mid-DIV together with a new offer: flush wins, result never appears
    issue(3'b100, 7'h01, 1'b0, 32'd100, 32'd7, 5'd13);
    repeat (14) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1;
    in_funct3 = 3'b000; in_funct7 = 7'h00; in_is_imm = 1'b0; in_rd = 5'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle", 32'(in_ready), 32'h1);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_noaccept", 32'(alu_opcode), 32'd6);
    risen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) risen++; end
    chk("flush_silent", 32'(risen), 32'h0);

    // Flush together with out_ready in DONE drops the result
    issue(3'b000, 7'h00, 1'b0, 32'd1, 32'd1, 5'd2);
    repeat (3) @(posedge clk);
    #1;
    chk("done_valid", 32'(out_valid), 32'h1);
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    chk("flush_done_valid", 32'(out_valid), 32'h0);
    chk("flush_done_idle", 32'(in_ready), 32'h1);

    // Reset mid-MUL clears everything
    issue(3'b000, 7'h01, 1'b0, 32'd3, 32'd9, 5'd17);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("rst_mid_valid", 32'(out_valid), 32'h0);
    chk("rst_mid_opcode", 32'(alu_opcode), 32'h0);
    chk("rst_mid_op1", alu_op1, 32'h0);
    chk("rst_mid_rd", 32'(out_rd), 32'h0);
    rst = 1'b0;
    run_op(3'b010, 7'h00, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd20, 0);     // SLTI after reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
